// File: rtl/output_acc.sv
// output_acc: result-side circular FIFO for a systolic-array column, with in-place partial-sum accumulate and valid/ready drain.
// Define OUTPUT_ACC_SAT_EN for a saturating accumulate; otherwise the accumulate add wraps.
module output_acc #(
  parameter int OUTPUT_ACC_DEPTH = 4,
  parameter int DATA_W = 16,
  localparam int CW = $clog2(OUTPUT_ACC_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              output_acc_valid_in,
  input  logic [DATA_W-1:0] output_acc_data_in,
  input  logic              output_acc_accum_in,
  input  logic              output_acc_pass_start,
  input  logic              output_acc_drain_in,
  input  logic              output_acc_ready_in,
  output logic              output_acc_valid_out,
  output logic [DATA_W-1:0] output_acc_data_out,
  output logic              output_acc_full,
  output logic              output_acc_empty,
  output logic              output_acc_overflow,
  output logic [CW-1:0]     output_acc_count
);
  localparam int PW = $clog2(OUTPUT_ACC_DEPTH);
  localparam logic [CW-1:0] DEP_C = CW'(OUTPUT_ACC_DEPTH);
  localparam logic [CW:0] DEP_W = (CW+1)'(OUTPUT_ACC_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(OUTPUT_ACC_DEPTH - 1);
  logic [DATA_W-1:0] mem [OUTPUT_ACC_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, acc_addr;
  logic [CW-1:0] count, acc_idx, idx_eff;
  logic [CW:0] asum;
  logic pop, enq, enq_ok, acc, acc_ok;
  logic [DATA_W-1:0] acc_val;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == LAST ? '0 : p + 1'b1;
  endfunction
  assign output_acc_count = count;
  assign output_acc_empty = count == '0;
  assign output_acc_full = count == DEP_C;
  assign output_acc_valid_out = output_acc_drain_in & ~output_acc_empty;
  assign output_acc_data_out = output_acc_empty ? '0 : mem[rd_ptr];
  assign pop = output_acc_valid_out & output_acc_ready_in;
  assign enq = output_acc_valid_in & ~output_acc_accum_in;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign enq_ok = enq & (~output_acc_full | pop);
  assign acc = output_acc_valid_in & output_acc_accum_in;
  assign idx_eff = output_acc_pass_start ? '0 : acc_idx;
  assign acc_ok = acc & ~output_acc_drain_in & (idx_eff < count);
  assign asum = (CW+1)'(rd_ptr) + (CW+1)'(idx_eff);
  assign acc_addr = asum >= DEP_W ? PW'(asum - DEP_W) : PW'(asum);
`ifdef OUTPUT_ACC_SAT_EN
  logic [DATA_W:0] wsum;
  assign wsum = {mem[acc_addr][DATA_W-1], mem[acc_addr]} + {output_acc_data_in[DATA_W-1], output_acc_data_in};
  assign acc_val = wsum[DATA_W] != wsum[DATA_W-1] ? {wsum[DATA_W], {(DATA_W-1){~wsum[DATA_W]}}} : wsum[DATA_W-1:0];
`else
  assign acc_val = mem[acc_addr] + output_acc_data_in;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      acc_idx <= '0;
      output_acc_overflow <= 1'b0;
      for (int i = 0; i < OUTPUT_ACC_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (enq_ok) begin
        mem[wr_ptr] <= output_acc_data_in;
        wr_ptr <= nxt(wr_ptr);
      end
      if (acc_ok) mem[acc_addr] <= acc_val;
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(enq_ok) - CW'(pop);
      acc_idx <= acc_ok ? idx_eff + 1'b1 :
                 output_acc_pass_start ? '0 :
                 (pop && acc_idx != '0) ? acc_idx - 1'b1 : acc_idx;
      if ((enq & ~enq_ok) | (acc & ~acc_ok)) output_acc_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_output_acc.sv
// tb_output_acc: directed vectors with hand-computed expectations for output_acc.
module tb_output_acc;
  logic clk = 1'b0;
  logic rst_n, valid_in, accum_in, pass_start, drain_in, ready_in;
  logic [15:0] data_in;
  logic valid_out, full, empty, overflow;
  logic [15:0] data_out;
  logic [2:0] count;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  output_acc dut (
    .clk(clk), .rst_n(rst_n),
    .output_acc_valid_in(valid_in), .output_acc_data_in(data_in),
    .output_acc_accum_in(accum_in), .output_acc_pass_start(pass_start),
    .output_acc_drain_in(drain_in), .output_acc_ready_in(ready_in),
    .output_acc_valid_out(valid_out), .output_acc_data_out(data_out),
    .output_acc_full(full), .output_acc_empty(empty),
    .output_acc_overflow(overflow), .output_acc_count(count)
  );
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic enq(input int v);
    valid_in = 1'b1; accum_in = 1'b0; data_in = 16'(v);
    tick();
    valid_in = 1'b0;
  endtask
  task automatic acc(input int v, input logic ps);
    valid_in = 1'b1; accum_in = 1'b1; pass_start = ps; data_in = 16'(v);
    tick();
    valid_in = 1'b0; accum_in = 1'b0; pass_start = 1'b0;
  endtask
  int exp5 [4] = '{2, 3, 4, 99};
  initial begin
    rst_n = 1'b0; valid_in = 1'b0; accum_in = 1'b0; pass_start = 1'b0;
    drain_in = 1'b0; ready_in = 1'b0; data_in = '0;
    @(negedge clk);
    tick(); tick();
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", $signed(data_out), 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) enq(10 * i);
    chk("t2_full", full, 1);
    chk("t2_count4", count, 4);
    chk("t2_ovf_pre", overflow, 0);
    enq(50);
    chk("t2_ovf", overflow, 1);
    chk("t2_count_drop", count, 4);
    drain_in = 1'b1; ready_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_valid", valid_out, 1);
      chk("t2_drain", $signed(data_out), 10 * i);
      tick();
    end
    chk("t2_empty", empty, 1);
    chk("t2_valid_end", valid_out, 0);
    drain_in = 1'b0; ready_in = 1'b0;
    do_reset();
    chk("t3_ovf_clr", overflow, 0);
    enq(100); enq(200);
    acc(5, 1'b1);
    acc(-7, 1'b0);
    chk("t3_ovf_ok", overflow, 0);
    acc(1, 1'b0);
    chk("t3_ovf_drop", overflow, 1);
    chk("t3_count", count, 2);
    drain_in = 1'b1; ready_in = 1'b1;
    #1;
    chk("t3_d0", $signed(data_out), 105);
    tick();
    chk("t3_d1", $signed(data_out), 193);
    tick();
    chk("t3_empty", empty, 1);
    drain_in = 1'b0; ready_in = 1'b0;
    enq(32000);
    acc(1000, 1'b1);
    drain_in = 1'b1;
    #1;
    chk("t4_valid", valid_out, 1);
`ifdef OUTPUT_ACC_SAT_EN
    chk("t4_sat", $signed(data_out), 32767);
`else
    chk("t4_wrap", $signed(data_out), -32536);
`endif
    ready_in = 1'b1;
    tick();
    chk("t4_empty", empty, 1);
    drain_in = 1'b0; ready_in = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) enq(i);
    chk("t5_full", full, 1);
    drain_in = 1'b1; ready_in = 1'b1;
    valid_in = 1'b1; data_in = 16'd99;
    #1;
    chk("t5_head", $signed(data_out), 1);
    tick();
    valid_in = 1'b0;
    chk("t5_count", count, 4);
    chk("t5_ovf", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_order", $signed(data_out), exp5[i]);
      tick();
    end
    chk("t5_empty", empty, 1);
    drain_in = 1'b0; ready_in = 1'b0;
    enq(7); enq(8);
    drain_in = 1'b1; ready_in = 1'b0;
    tick();
    chk("t6_hold", $signed(data_out), 7);
    chk("t6_hold_cnt", count, 2);
    ready_in = 1'b1;
    tick();
    chk("t6_next", $signed(data_out), 8);
    ready_in = 1'b0;
    tick();
    chk("t6_hold8", $signed(data_out), 8);
    ready_in = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; ready_in = 1'b0;
    #1;
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_valid", valid_out, 0);
    chk("t6_rst_count", count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
